// File: rtl/grf_wport_arbiter_if.sv
// Two-requester writeback bus feeding the GRF write-port arbiter.
// master = requesters (pipeline WB on port 0, multi-cycle unit on port 1), slave = arbiter.
interface grf_wport_arbiter_if;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready
    );
endinterface

// File: rtl/grf_wport_arbiter.sv
// Fixed-priority GRF write-port arbiter with starvation guard for port 1 and a registered A3/WD/En stage.
// Optional simulation trace of GRF writes and forced grants: define GRF_ARB_TRACE_EN.
module grf_wport_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    grf_wport_arbiter_if.slave   req,
    output logic [4:0]           A3,
    output logic [31:0]          WD,
    output logic                 En,
    output logic [CNT_W-1:0]     starve_cnt
);
    localparam logic [CNT_W-1:0] LP_STARVE_MAX = CNT_W'(STARVE_MAX);

    logic             w_both;
    logic             w_force;
    logic             w_grant0;
    logic             w_grant1;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [CNT_W-1:0] r_starve_cnt;
    logic [4:0]       r_a3;
    logic [31:0]      r_wd;
    logic             r_en;

    // Grant selection and next starvation count
    always_comb begin
        w_both    = req.req0_valid && req.req1_valid;
        w_force   = (r_starve_cnt >= LP_STARVE_MAX);
        w_grant0  = 1'b0;
        w_grant1  = 1'b0;
        w_cnt_nxt = {CNT_W{1'b0}};
        if (!reset) begin
            w_grant0  = 1'b0;
            w_grant1  = 1'b0;
            w_cnt_nxt = {CNT_W{1'b0}};
        end else if (w_both && !w_force) begin
            // port 1 loses again; counter cannot pass STARVE_MAX since it only grows below it
            w_grant0  = 1'b1;
            w_cnt_nxt = r_starve_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (w_both) begin
            w_grant1  = 1'b1;
        end else if (req.req0_valid) begin
            w_grant0  = 1'b1;
        end else if (req.req1_valid) begin
            w_grant1  = 1'b1;
        end else begin
            w_grant0  = 1'b0;
        end
    end

    assign req.req0_ready = w_grant0;
    assign req.req1_ready = w_grant1;

    // Starvation counter and registered GRF write stage
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_starve_cnt <= {CNT_W{1'b0}};
            r_a3         <= 5'd0;
            r_wd         <= 32'd0;
            r_en         <= 1'b0;
        end else begin
            r_starve_cnt <= w_cnt_nxt;
            if (w_grant0) begin
                r_a3 <= req.req0_addr;
                r_wd <= req.req0_data;
                r_en <= (req.req0_addr != 5'd0);
            end else if (w_grant1) begin
                r_a3 <= req.req1_addr;
                r_wd <= req.req1_data;
                r_en <= (req.req1_addr != 5'd0);
            end else begin
                r_en <= 1'b0;
            end
        end
    end

    assign A3         = r_a3;
    assign WD         = r_wd;
    assign En         = r_en;
    assign starve_cnt = r_starve_cnt;

`ifdef GRF_ARB_TRACE_EN
    logic r_src;

    // Remember which port produced the pending write, for the trace only
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_src <= 1'b0;
        end else if (w_grant1) begin
            r_src <= 1'b1;
        end else if (w_grant0) begin
            r_src <= 1'b0;
        end else begin
            r_src <= r_src;
        end
    end

    // Simulation trace of committed writes and forced grants
    always_ff @(posedge clk) begin
        if (En) begin
            $display("%0t grf_arb: port %0d $%0d <= %h", $time, r_src, A3, WD);
        end
        if (reset && w_both && w_grant1) begin
            $display("%0t grf_arb: starve grant", $time);
        end
    end
`else
    // trace disabled: no simulation-only logic is built
`endif

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Directed self-checking bench for grf_wport_arbiter (STARVE_MAX=4, CNT_W=4).
module tb_grf_wport_arbiter;
    logic        clk;
    logic        reset;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic        En;
    logic [3:0]  starve_cnt;
    logic [31:0] grf [0:31];

    int checks = 0;
    int errors = 0;

    grf_wport_arbiter_if bus ();

    grf_wport_arbiter #(.STARVE_MAX(4), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (bus),
        .A3         (A3),
        .WD         (WD),
        .En         (En),
        .starve_cnt (starve_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the GRF consuming the write port one cycle after acceptance
    always @(posedge clk) begin
        if (En === 1'b1) grf[A3] <= WD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [4:0] a3,
                           input logic [31:0] wd, input logic [3:0] cnt);
        chk({tag, ".En"}, {31'd0, En}, {31'd0, en});
        chk({tag, ".A3"}, {27'd0, A3}, {27'd0, a3});
        chk({tag, ".WD"}, WD, wd);
        chk({tag, ".cnt"}, {28'd0, starve_cnt}, {28'd0, cnt});
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, ".ready0"}, {31'd0, bus.req0_ready}, {31'd0, r0});
        chk({tag, ".ready1"}, {31'd0, bus.req1_ready}, {31'd0, r1});
    endtask

    initial begin
        logic [9:0] exp_g;
        logic [3:0] exp_c;

        for (int k = 0; k < 32; k++) grf[k] = 32'd0;

        // 1. reset holds both ports off
        reset = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'h0000_00AA;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd6; bus.req1_data = 32'h0000_00BB;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_rdy("rst", 1'b0, 1'b0);
            chk_out("rst", 1'b0, 5'd0, 32'd0, 4'd0);
        end
        reset = 1'b1;
        bus.req1_valid = 1'b0;
        bus.req0_addr = 5'd1; bus.req0_data = 32'h0000_0004;
        #1;
        chk_rdy("rel", 1'b1, 1'b0);
        tick();
        chk_out("rel", 1'b1, 5'd1, 32'h0000_0004, 4'd0);

        // 2. starvation: grants 0,0,0,0,1 twice
        bus.req0_addr = 5'd2; bus.req0_data = 32'h0000_0222;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd3; bus.req1_data = 32'h0000_0333;
        exp_g = 10'b10000_10000;
        for (int i = 0; i < 10; i++) begin
            exp_c = 4'(i % 5);
            #1;
            chk("starve.cnt_pre", {28'd0, starve_cnt}, {28'd0, exp_c});
            chk_rdy("starve", !exp_g[i], exp_g[i]);
            tick();
            chk("starve.A3", {27'd0, A3}, exp_g[i] ? 32'd3 : 32'd2);
            chk("starve.WD", WD, exp_g[i] ? 32'h0000_0333 : 32'h0000_0222);
            chk("starve.En", {31'd0, En}, 32'd1);
        end
        chk("starve.cnt_end", {28'd0, starve_cnt}, 32'd0);

        // 3. write to $0 is accepted but not enabled
        bus.req0_valid = 1'b0;
        bus.req1_addr = 5'd0; bus.req1_data = 32'hDEAD_BEEF;
        #1;
        chk_rdy("zero", 1'b0, 1'b1);
        tick();
        chk_out("zero", 1'b0, 5'd0, 32'hDEAD_BEEF, 4'd0);

        // 4. same-address conflict: loser lands last
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd31; bus.req0_data = 32'd1;
        bus.req1_addr = 5'd31; bus.req1_data = 32'd8;
        #1;
        chk_rdy("conf0", 1'b1, 1'b0);
        tick();
        chk_out("conf0", 1'b1, 5'd31, 32'd1, 4'd1);
        bus.req0_valid = 1'b0;
        #1;
        chk_rdy("conf1", 1'b0, 1'b1);
        tick();
        chk_out("conf1", 1'b1, 5'd31, 32'd8, 4'd0);

        // 5. reset drops while req1 would be granted
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd4; bus.req0_data = 32'd44;
        bus.req1_addr = 5'd7; bus.req1_data = 32'd77;
        #1;
        chk_rdy("mid0", 1'b1, 1'b0);
        tick();
        chk("grf31", grf[31], 32'd8);
        chk_out("mid0", 1'b1, 5'd4, 32'd44, 4'd1);
        bus.req0_valid = 1'b0;
        #1;
        chk_rdy("mid_pre", 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        chk_rdy("mid_rst", 1'b0, 1'b0);
        tick();
        chk_out("mid_rst", 1'b0, 5'd0, 32'd0, 4'd0);
        reset = 1'b1;
        #1;
        chk_rdy("mid_rel", 1'b0, 1'b1);
        tick();
        chk_out("mid_rel", 1'b1, 5'd7, 32'd77, 4'd0);

        // 6. idle: outputs hold, no enable
        bus.req1_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk_rdy("idle", 1'b0, 1'b0);
            tick();
            chk_out("idle", 1'b0, 5'd7, 32'd77, 4'd0);
        end
        chk("grf7", grf[7], 32'd77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
